// File: rtl/vga_pkg.sv
// Shared widths, swap FSM encoding and write-queue entry type for the frame-buffer arbiter.
// Holds types only: no logic, no latency, no backpressure.
package vga_pkg;
    localparam int FB_ADDR_W = 20;
    localparam int FB_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } swap_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } wr_entry_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundles the scanout, game-write, swap-control and pixel-RAM signals of the arbiter.
// Wires only: no latency, no backpressure of its own.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = vga_pkg::FB_ADDR_W,
    parameter int DATA_W = vga_pkg::FB_DATA_W
);
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_start;
    logic              swap_req;
    logic              swap_ack;
    logic              front_buf;
    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  scan_req, scan_addr, wr_valid, wr_addr, wr_data,
               frame_start, swap_req, mem_rdata,
        output scan_valid, scan_data, wr_ready, swap_ack, front_buf,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output scan_req, scan_addr, wr_valid, wr_addr, wr_data,
               frame_start, swap_req, mem_rdata,
        input  scan_valid, scan_data, wr_ready, swap_ack, front_buf,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_write_fifo.sv
// Small circular write queue; head is readable combinationally, one push and one pop per cycle.
// Push while full and pop while empty are ignored; the producer owns flow control.
module fb_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port pixel RAM shared by scanout (priority, 2-cycle read) and a queued back-bank writer.
// Writes stall via wr_ready when the queue fills or a bank swap is pending.
module vga_fb_arbiter #(
    parameter int ADDR_W   = vga_pkg::FB_ADDR_W,
    parameter int DATA_W   = vga_pkg::FB_DATA_W,
    parameter int WQ_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    vga_fb_arbiter_if.slave  bus
);
    import vga_pkg::*;

    localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = WQ_DEPTH[CNT_W-1:0];

    swap_state_t      state;
    wr_entry_t        push_ent;
    wr_entry_t        head_ent;
    logic             push;
    logic             pop;
    logic             wq_full;
    logic             wq_empty;
    logic [CNT_W-1:0] wq_count;
    logic [CNT_W-1:0] count_next;
    logic             room;
    logic             scan_d1;

    assign push_ent = '{addr: bus.wr_addr, data: bus.wr_data};
    assign push     = bus.wr_valid && bus.wr_ready && !wq_full;
    assign pop      = !bus.scan_req && !wq_empty;

    fb_write_fifo #(
        .DEPTH (WQ_DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_wq (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head     (head_ent),
        .full     (wq_full),
        .empty    (wq_empty),
        .count    (wq_count)
    );

    // wr_ready is registered from next cycle's occupancy so a push can never overrun.
    always_comb begin
        count_next = wq_count;
        if (push && !pop) begin
            count_next = wq_count + 1'b1;
        end else if (!push && pop) begin
            count_next = wq_count - 1'b1;
        end
    end
    assign room = (count_next < FULL_CNT);

    // Scan data comes straight off the RAM; the RAM's own register is the second stage.
    assign bus.scan_data = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= '0;
            scan_d1        <= 1'b0;
            bus.scan_valid <= 1'b0;
        end else begin
            scan_d1        <= bus.scan_req;
            bus.scan_valid <= scan_d1;
            bus.mem_we     <= 1'b0;
            if (bus.scan_req) begin
                bus.mem_addr <= {bus.front_buf, bus.scan_addr};
            end else if (!wq_empty) begin
                bus.mem_addr  <= {~bus.front_buf, head_ent.addr};
                bus.mem_wdata <= head_ent.data;
                bus.mem_we    <= 1'b1;
            end
        end
    end

    // The bank flips on entry to SWAP, so arbitration in the SWAP cycle already sees the new front.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.front_buf <= 1'b0;
            bus.swap_ack  <= 1'b0;
            bus.wr_ready  <= 1'b0;
        end else begin
            bus.swap_ack <= 1'b0;
            bus.wr_ready <= room;
            case (state)
                IDLE: begin
                    if (bus.swap_req) begin
                        state        <= PENDING;
                        bus.wr_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    bus.wr_ready <= 1'b0;
                    if (bus.frame_start && wq_empty && !pop) begin
                        state         <= SWAP;
                        bus.front_buf <= ~bus.front_buf;
                        bus.swap_ack  <= 1'b1;
                        bus.wr_ready  <= room;
                    end
                end
                SWAP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed and random stimulus for vga_fb_arbiter, checked against a transaction-level model
// of the write queue, bank swap and pixel memory.
module tb_vga_fb_arbiter;
    localparam int AW = 20;
    localparam int DW = 24;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] pre(input logic [AW:0] a);
        return 24'hA5A5A5 ^ {3'b000, a};
    endfunction

    // Pixel RAM: synchronous read-before-write, one-cycle read latency.
    logic [DW-1:0] ram [logic [AW:0]];
    always @(posedge clk) begin
        bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : pre(bus.mem_addr);
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] = bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: FIFO of accepted writes, pending-swap flag, model front bank and memory.
    ent_t          q[$];
    logic [DW-1:0] mm [logic [AW:0]];
    logic          m_front = 1'b0, m_pend = 1'b0, ack_last = 1'b0, exp_ready = 1'b0;
    logic          p_rst = 1'b1, p_scan = 1'b0, p_swap = 1'b0, p_fs = 1'b0, p_push = 1'b0;
    logic          p2_scan = 1'b0;
    logic [AW-1:0] p_saddr = '0;
    logic [AW:0]   p2_full = '0;
    ent_t          p_ent;

    always @(negedge clk) begin : monitor
        logic        exp_we, exp_ack, exp_v;
        logic [AW:0] pfull, wa;
        ent_t        e;
        exp_v = p2_scan && !p_rst;
        chk("mon_scan_valid", bus.scan_valid, exp_v);
        if (exp_v) chk("mon_scan_data", bus.scan_data, mm.exists(p2_full) ? mm[p2_full] : pre(p2_full));
        pfull   = {m_front, p_saddr};
        exp_we  = 1'b0;
        exp_ack = 1'b0;
        if (p_rst) begin
            q.delete();
            m_front = 1'b0;
            m_pend  = 1'b0;
        end else begin
            exp_we  = !p_scan && (q.size() > 0);
            exp_ack = m_pend && p_fs && (q.size() == 0);
            if (p_scan) chk("mon_scan_addr", bus.mem_addr, pfull);
            if (exp_we) begin
                e  = q.pop_front();
                wa = {~m_front, e.a};
                chk("mon_wr_addr", bus.mem_addr, wa);
                chk("mon_wr_data", bus.mem_wdata, e.d);
                mm[wa] = e.d;
            end
            if (p_push) q.push_back(p_ent);
            if (exp_ack) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
            end else if (!m_pend && p_swap && !ack_last) begin
                m_pend = 1'b1;
            end
        end
        chk("mon_mem_we", bus.mem_we, exp_we);
        chk("mon_swap_ack", bus.swap_ack, exp_ack);
        chk("mon_front_buf", bus.front_buf, m_front);
        exp_ready = !p_rst && !m_pend && (q.size() < 4);
        chk("mon_wr_ready", bus.wr_ready, exp_ready);
        ack_last = exp_ack;
        p2_scan  = p_scan && !p_rst;
        p2_full  = pfull;
        p_rst    = rst;
        p_scan   = bus.scan_req;
        p_saddr  = bus.scan_addr;
        p_swap   = bus.swap_req;
        p_fs     = bus.frame_start;
        p_push   = bus.wr_valid && exp_ready && !rst;
        p_ent    = '{a: bus.wr_addr, d: bus.wr_data};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.scan_req = 1'b0; bus.scan_addr = '0; bus.wr_valid = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.frame_start = 1'b0; bus.swap_req = 1'b0;

        // 1. reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_scan_valid", bus.scan_valid, 0);
        chk("rst_swap_ack", bus.swap_ack, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_front_buf", bus.front_buf, 0);
        cyc(); rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("rel_wr_ready", bus.wr_ready, 1);
        chk("rel_front_buf", bus.front_buf, 0);

        // 2. scan only, addresses 0..3
        for (int i = 0; i < 7; i++) begin
            cyc();
            bus.scan_req  = (i < 4);
            bus.scan_addr = (i < 4) ? AW'(i) : '0;
            @(negedge clk);
            if (i >= 1 && i <= 4) chk("scan_mem_addr", bus.mem_addr, 32'(i - 1));
            chk("scan_valid", bus.scan_valid, (i >= 2 && i <= 5));
            if (i >= 2 && i <= 5) chk("scan_data", bus.scan_data, pre(21'(i - 2)));
        end

        // 3. contention: scan held 8 cycles while writes keep arriving
        for (int i = 0; i < 14; i++) begin
            cyc();
            bus.scan_req = (i < 8); bus.scan_addr = 20'h10;
            bus.wr_valid = (i < 8); bus.wr_addr = 20'h5; bus.wr_data = 24'hFF0000;
            @(negedge clk);
            if (i < 8) chk("cont_wr_ready", bus.wr_ready, (i < 4));
            if (i >= 1 && i <= 8) chk("cont_no_write", bus.mem_we, 0);
            if (i >= 9) chk("cont_we", bus.mem_we, (i <= 12));
            if (i >= 9 && i <= 12) chk("cont_wr_addr", bus.mem_addr, {1'b1, 20'h5});
        end

        // 4. swap: 3 writes, swap_req, frame_start 20 cycles later
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.wr_valid = 1'b1; bus.wr_addr = 20'h7 + AW'(i); bus.wr_data = 24'h123450 + DW'(i);
        end
        cyc(); bus.wr_valid = 1'b0; bus.swap_req = 1'b1;
        @(negedge clk);
        chk("swap_req_ack", bus.swap_ack, 0);
        for (int i = 1; i <= 22; i++) begin
            cyc();
            bus.swap_req = 1'b0; bus.frame_start = (i == 20);
            @(negedge clk);
            if (i <= 20) chk("swap_wr_ready", bus.wr_ready, 0);
            chk("swap_ack", bus.swap_ack, (i == 21));
            chk("swap_front", bus.front_buf, (i >= 21));
        end
        cyc(); bus.frame_start = 1'b0; bus.scan_req = 1'b1; bus.scan_addr = 20'h7;
        cyc(); bus.scan_req = 1'b0;
        @(negedge clk);
        chk("swap_scan_bank", bus.mem_addr, {1'b1, 20'h7});
        cyc();
        @(negedge clk);
        chk("swap_scan_data", bus.scan_data, 24'h123450);

        // 6. reset while PENDING with 2 queued writes
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.scan_req = 1'b1; bus.wr_valid = (i < 2);
            bus.wr_addr = 20'h20 + AW'(i); bus.wr_data = 24'h0F0F00 + DW'(i); bus.swap_req = (i == 2);
        end
        cyc(); bus.swap_req = 1'b0; bus.wr_valid = 1'b0; rst = 1'b1;
        cyc();
        cyc(); rst = 1'b0; bus.scan_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            bus.frame_start = (i == 3);
            @(negedge clk);
            chk("rmid_mem_we", bus.mem_we, 0);
            chk("rmid_swap_ack", bus.swap_ack, 0);
            chk("rmid_front", bus.front_buf, 0);
            chk("rmid_wr_ready", bus.wr_ready, 1);
        end

        // 5. deferred swap: queue blocked by scan at the first frame_start
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.frame_start = 1'b0; bus.scan_req = 1'b1; bus.wr_valid = (i < 2);
            bus.wr_addr = 20'h30 + AW'(i); bus.wr_data = 24'h00AB00 + DW'(i); bus.swap_req = (i == 2);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            bus.wr_valid = 1'b0; bus.swap_req = 1'b0; bus.frame_start = (i == 2);
            @(negedge clk);
            chk("defer_no_ack", bus.swap_ack, 0);
            chk("defer_front", bus.front_buf, 0);
        end
        cyc(); bus.frame_start = 1'b0; bus.scan_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cyc();
            bus.frame_start = (j == 4);
            @(negedge clk);
            chk("defer_ack", bus.swap_ack, (j == 5));
            chk("defer_front_late", bus.front_buf, (j >= 5));
            chk("defer_wr_ready", bus.wr_ready, (j >= 5));
        end

        // random traffic, checked by the monitor
        for (int c = 0; c < 400; c++) begin
            cyc();
            bus.scan_req    = ($urandom_range(0, 1) == 1);
            bus.scan_addr   = AW'($urandom_range(0, 15));
            bus.wr_valid    = ($urandom_range(0, 9) < 6);
            bus.wr_addr     = AW'($urandom_range(0, 15));
            bus.wr_data     = DW'($urandom);
            bus.swap_req    = ($urandom_range(0, 19) == 0);
            bus.frame_start = ($urandom_range(0, 14) == 0);
        end
        cyc();
        bus.scan_req = 1'b0; bus.wr_valid = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
